udp_hdr_tx_bp: RTL and testbench

Parametrised UDP header serializer, successor to the free-running header transmitter. A single `start` pulse latches the ports, lengths and IPs, plus a precomputed payload one's-complement sum. The block then computes the full IPv4 pseudo-header UDP checksum sequentially and streams the 8-byte header N bits per beat. The output honours a downstream `axi_ready` backpressure handshake. It sits between the frame builder (which supplies fields and the payload sum) and the IPv4/Ethernet TX muxer (which consumes the header stream before the payload).

---
 rtl/udp_pkg.sv | 19 +
 rtl/ones_comp_acc.sv | 35 +++
 rtl/udp_hdr_tx_bp.sv | 204 ++++++++++++++++++++
 tb/tb_udp_hdr_tx_bp.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: protocol constants, FSM state type and
// a one's-complement add helper used by the checksum datapaths.
package udp_pkg;

  localparam logic [15:0] UDP_PROTO       = 16'h0011;
  localparam int unsigned UDP_HDR_BYTES   = 8;
  localparam logic [15:0] MAX_UDP_PAYLOAD = 16'hFFF7;
  localparam int unsigned CALC_TERMS      = 10;

  typedef enum logic [1:0] {IDLE, CALC, FIN, SEND} tx_state_t;

  // 16-bit one's-complement add; the carry is folded back immediately.
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s17;
    s17 = {1'b0, a} + {1'b0, b};
    return s17[15:0] + {15'd0, s17[16]};
  endfunction

endpackage

// File: rtl/ones_comp_acc.sv
// Single-cycle 16-bit one's-complement accumulator with end-around carry.
// clear has priority over add_valid.
module ones_comp_acc
  import udp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        add_valid,
  input  logic [15:0] term,
  output logic [15:0] acc
);

  logic [15:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = 16'd0;
    end else if (add_valid) begin
      acc_d = ones_add(acc_q, term);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 16'd0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/udp_hdr_tx_bp.sv
// UDP header serializer: latches fields on start, computes the pseudo-header
// checksum one term per cycle, then streams the 8-byte header N bits per beat.
module udp_hdr_tx_bp
  import udp_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter bit          CKSUM_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  src_port,
  input  logic [15:0]  dst_port,
  input  logic [15:0]  payload_len,
  input  logic [15:0]  payload_cksum,
  input  logic [31:0]  src_ip,
  input  logic [31:0]  dst_ip,
  output logic         busy,
  output logic         err,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         axi_last,
  input  logic         axi_ready
);

  localparam int unsigned NBEATS    = UDP_HDR_BYTES * 8 / N;
  localparam logic [6:0]  LAST_BEAT = 7'(NBEATS - 1);
  localparam logic [3:0]  LAST_TERM = 4'(CALC_TERMS - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] dst_port_q, dst_port_d;
  logic [15:0] udp_len_q, udp_len_d;
  logic [15:0] pay_ck_q, pay_ck_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] dst_ip_q, dst_ip_d;
  logic [15:0] cksum_q, cksum_d;
  logic [3:0]  term_idx_q, term_idx_d;
  logic [6:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        axiov_q, axiov_d;
  logic [N-1:0] axiod_q, axiod_d;
  logic        last_q, last_d;

  logic        acc_clear;
  logic [15:0] term;
  logic [15:0] acc;
  logic [15:0] cksum_raw;
  logic [63:0] hdr;

  assign hdr       = {src_port_q, dst_port_q, udp_len_q, cksum_q};
  assign cksum_raw = ~acc;

  function automatic logic [N-1:0] beat_data(input logic [63:0] h, input logic [6:0] idx);
    logic [63:0] sh;
    sh = h << (N * idx);
    return sh[63 -: N];
  endfunction

  always_comb begin
    term = 16'd0;
    case (term_idx_q)
      4'd0:    term = src_ip_q[31:16];
      4'd1:    term = src_ip_q[15:0];
      4'd2:    term = dst_ip_q[31:16];
      4'd3:    term = dst_ip_q[15:0];
      4'd4:    term = UDP_PROTO;
      4'd5:    term = udp_len_q;
      4'd6:    term = src_port_q;
      4'd7:    term = dst_port_q;
      4'd8:    term = udp_len_q;
      4'd9:    term = pay_ck_q;
      default: term = 16'd0;
    endcase
  end

  ones_comp_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .add_valid(state_q == CALC),
    .term     (term),
    .acc      (acc)
  );

  always_comb begin
    state_d    = state_q;
    src_port_d = src_port_q;
    dst_port_d = dst_port_q;
    udp_len_d  = udp_len_q;
    pay_ck_d   = pay_ck_q;
    src_ip_d   = src_ip_q;
    dst_ip_d   = dst_ip_q;
    cksum_d    = cksum_q;
    term_idx_d = term_idx_q;
    beat_d     = beat_q;
    busy_d     = busy_q;
    err_d      = 1'b0;
    axiov_d    = axiov_q;
    axiod_d    = axiod_q;
    last_d     = last_q;
    acc_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (payload_len > MAX_UDP_PAYLOAD) begin
            err_d = 1'b1;
          end else begin
            src_port_d = src_port;
            dst_port_d = dst_port;
            udp_len_d  = payload_len + 16'(UDP_HDR_BYTES);
            pay_ck_d   = payload_cksum;
            src_ip_d   = src_ip;
            dst_ip_d   = dst_ip;
            cksum_d    = 16'd0;
            term_idx_d = 4'd0;
            beat_d     = 7'd0;
            busy_d     = 1'b1;
            acc_clear  = 1'b1;
            state_d    = CKSUM_EN ? CALC : SEND;
          end
        end
      end
      CALC: begin
        term_idx_d = term_idx_q + 4'd1;
        if (term_idx_q == LAST_TERM) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // A computed checksum of zero is sent as all-ones; zero means "none".
        cksum_d = (cksum_raw == 16'd0) ? 16'hFFFF : cksum_raw;
        state_d = SEND;
      end
      SEND: begin
        if (!axiov_q) begin
          axiov_d = 1'b1;
          beat_d  = 7'd0;
          axiod_d = beat_data(hdr, 7'd0);
          last_d  = (LAST_BEAT == 7'd0);
        end else if (axi_ready) begin
          if (beat_q == LAST_BEAT) begin
            axiov_d = 1'b0;
            axiod_d = '0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            beat_d  = 7'd0;
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 7'd1;
            axiod_d = beat_data(hdr, beat_q + 7'd1);
            last_d  = ((beat_q + 7'd1) == LAST_BEAT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      src_port_q <= 16'd0;
      dst_port_q <= 16'd0;
      udp_len_q  <= 16'd0;
      pay_ck_q   <= 16'd0;
      src_ip_q   <= 32'd0;
      dst_ip_q   <= 32'd0;
      cksum_q    <= 16'd0;
      term_idx_q <= 4'd0;
      beat_q     <= 7'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      axiov_q    <= 1'b0;
      axiod_q    <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_port_q <= src_port_d;
      dst_port_q <= dst_port_d;
      udp_len_q  <= udp_len_d;
      pay_ck_q   <= pay_ck_d;
      src_ip_q   <= src_ip_d;
      dst_ip_q   <= dst_ip_d;
      cksum_q    <= cksum_d;
      term_idx_q <= term_idx_d;
      beat_q     <= beat_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      axiov_q    <= axiov_d;
      axiod_q    <= axiod_d;
      last_q     <= last_d;
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign axiov    = axiov_q;
  assign axiod    = axiod_q;
  assign axi_last = last_q;

endmodule

// File: tb/tb_udp_hdr_tx_bp.sv
// Bench for udp_hdr_tx_bp: two instances (N=2 with checksum, N=8 without)
// share stimulus and are compared every cycle against a transaction-level model.
module tb_udp_hdr_tx_bp;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] src_port, dst_port, payload_len, payload_cksum;
  logic [31:0] src_ip, dst_ip;
  logic [1:0]  rdy;

  logic       busy0, err0, axiov0, last0;
  logic [1:0] axiod0;
  logic       busy1, err1, axiov1, last1;
  logic [7:0] axiod1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rdy_mode = 0;
  int rdy_pat = 0;

  always #5 clk = ~clk;

  udp_hdr_tx_bp #(.N(2), .CKSUM_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .src_port(src_port), .dst_port(dst_port),
    .payload_len(payload_len), .payload_cksum(payload_cksum), .src_ip(src_ip),
    .dst_ip(dst_ip), .busy(busy0), .err(err0), .axiov(axiov0), .axiod(axiod0),
    .axi_last(last0), .axi_ready(rdy[0])
  );

  udp_hdr_tx_bp #(.N(8), .CKSUM_EN(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .src_port(src_port), .dst_port(dst_port),
    .payload_len(payload_len), .payload_cksum(payload_cksum), .src_ip(src_ip),
    .dst_ip(dst_ip), .busy(busy1), .err(err1), .axiov(axiov1), .axiod(axiod1),
    .axi_last(last1), .axi_ready(rdy[1])
  );

  function automatic int nw(input int d);
    return (d == 0) ? 2 : 8;
  endfunction

  // Expected header from the protocol rules, summing everything then folding.
  function automatic logic [63:0] ref_hdr(input bit ck, input logic [15:0] sp,
      input logic [15:0] dp, input logic [15:0] len, input logic [15:0] pc,
      input logic [31:0] sip, input logic [31:0] dip);
    logic [15:0] ulen, c;
    int unsigned s;
    ulen = len + 16'd8;
    c = 16'd0;
    if (ck) begin
      s = 32'(sip[31:16]) + 32'(sip[15:0]) + 32'(dip[31:16]) + 32'(dip[15:0]) + 32'd17
        + 32'(ulen) + 32'(sp) + 32'(dp) + 32'(ulen) + 32'(pc);
      while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
      c = ~s[15:0];
      if (c == 16'd0) c = 16'hFFFF;
    end
    return {sp, dp, ulen, c};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model state per instance
  bit          m_busy[2], m_valid[2], m_err[2];
  int          m_wait[2], m_beat[2];
  logic [63:0] m_hdr[2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 0; m_valid[d] = 0; m_err[d] = 0; m_beat[d] = 0; m_wait[d] = 0;
      end else begin
        m_err[d] = 0;
        if (!m_busy[d]) begin
          if (start) begin
            if (payload_len > 16'hFFF7) begin
              m_err[d] = 1;
            end else begin
              m_busy[d]  = 1;
              m_valid[d] = 0;
              m_beat[d]  = 0;
              m_hdr[d]   = ref_hdr(d == 0, src_port, dst_port, payload_len, payload_cksum,
                                   src_ip, dst_ip);
              m_wait[d]  = (d == 0) ? 12 : 1;
            end
          end
        end else if (m_valid[d]) begin
          if (rdy[d]) begin
            if (m_beat[d] == 64 / nw(d) - 1) begin
              m_busy[d] = 0; m_valid[d] = 0; m_beat[d] = 0;
            end else begin
              m_beat[d]++;
            end
          end
        end else begin
          m_wait[d]--;
          if (m_wait[d] == 0) m_valid[d] = 1;
        end
      end
    end
  end

  // Frame reassembly from the DUT side, for literal header checks
  logic [63:0] asm_hdr[2], done_hdr[2];
  int          cnt[2], done_cnt[2], frames[2];

  task automatic check_dut(input int d, input logic ov, input logic [7:0] od,
                           input logic lst, input logic bsy, input logic er);
    logic [63:0] exp_d;
    int nb;
    nb = 64 / nw(d);
    chk($sformatf("dut%0d_axiov", d), 64'(ov), 64'(m_valid[d]));
    chk($sformatf("dut%0d_busy", d), 64'(bsy), 64'(m_busy[d]));
    chk($sformatf("dut%0d_err", d), 64'(er), 64'(m_err[d]));
    chk($sformatf("dut%0d_last", d), 64'(lst), 64'(m_valid[d] && m_beat[d] == nb - 1));
    if (m_valid[d]) begin
      exp_d = (m_hdr[d] << (nw(d) * m_beat[d])) >> (64 - nw(d));
      chk($sformatf("dut%0d_data_beat%0d", d, m_beat[d]), 64'(od), exp_d);
    end
    if (rst) begin
      asm_hdr[d] = 0; cnt[d] = 0;
    end else if (ov && rdy[d]) begin
      asm_hdr[d] = (asm_hdr[d] << nw(d)) | 64'(od);
      cnt[d]++;
      if (lst) begin
        done_hdr[d] = asm_hdr[d]; done_cnt[d] = cnt[d]; frames[d]++;
        asm_hdr[d] = 0; cnt[d] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_dut(0, axiov0, {6'd0, axiod0}, last0, busy0, err0);
      check_dut(1, axiov1, axiod1, last1, busy1, err1);
    end
  end

  always @(posedge clk) begin
    #1;
    rdy_pat++;
    case (rdy_mode)
      0: rdy = 2'b11;
      1: rdy = {1'b1, (rdy_pat % 4 == 0) || (rdy_pat % 4 == 3)};
      default: rdy = {1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0)};
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_case1(input logic [15:0] pc);
    src_ip = 32'hC0A80102; dst_ip = 32'hC0A80101;
    src_port = 16'h1234; dst_port = 16'h5678;
    payload_len = 16'h0004; payload_cksum = pc;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((m_busy[0] || m_busy[1]) && k < budget) begin
      tick();
      k++;
    end
    if (m_busy[0] || m_busy[1]) begin
      checks++;
      errors++;
      $display("FAIL wait_idle timeout actual=busy required=idle at %0t", $time);
    end
    tick();
  endtask

  initial begin
    int f0, f1, k;
    logic [63:0] exp_case1;
    rst = 1'b1; start = 1'b0; rdy = 2'b00;
    set_case1(16'h0000);
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Pin the model against hand-derived headers
    exp_case1 = ref_hdr(1, 16'h1234, 16'h5678, 16'h0004, 16'h0000, 32'hC0A80102, 32'hC0A80101);
    chk("pin_case1", exp_case1, 64'h12345678000C13D6);
    chk("pin_zero_sub", ref_hdr(1, 16'h1234, 16'h5678, 16'h0004, 16'h13D6, 32'hC0A80102,
        32'hC0A80101), 64'h12345678000CFFFF);
    chk("pin_nocksum", ref_hdr(0, 16'h1234, 16'h5678, 16'h0004, 16'h0000, 32'hC0A80102,
        32'hC0A80101), 64'h12345678000C0000);

    // Case 1 with a start pulse while both instances are busy
    f0 = frames[0]; f1 = frames[1];
    pulse_start();
    tick(); tick();
    src_port = 16'hAAAA;
    pulse_start();
    src_port = 16'h1234;
    wait_idle(200);
    chk("c1_frames0", 64'(frames[0] - f0), 64'd1);
    chk("c1_hdr0", done_hdr[0], 64'h12345678000C13D6);
    chk("c1_beats0", 64'(done_cnt[0]), 64'd32);
    chk("c1_frames1", 64'(frames[1] - f1), 64'd1);
    chk("c1_hdr1", done_hdr[1], 64'h12345678000C0000);
    chk("c1_beats1", 64'(done_cnt[1]), 64'd8);

    // Case 2: checksum folds to zero, sent as FFFF
    set_case1(16'h13D6);
    pulse_start();
    wait_idle(200);
    chk("c2_hdr0", done_hdr[0], 64'h12345678000CFFFF);

    // Case 3: backpressure pattern 1,0,0,1
    set_case1(16'h0000);
    rdy_mode = 1;
    pulse_start();
    wait_idle(400);
    rdy_mode = 0;
    chk("c3_hdr0", done_hdr[0], 64'h12345678000C13D6);
    chk("c3_beats0", 64'(done_cnt[0]), 64'd32);

    // Case 4: illegal length, then the maximum legal length
    f0 = frames[0];
    payload_len = 16'hFFF8;
    pulse_start();
    tick(); tick(); tick();
    chk("c4_no_frame", 64'(frames[0] - f0), 64'd0);
    payload_len = 16'hFFF7;
    pulse_start();
    wait_idle(200);
    chk("c4_udp_len0", 64'(done_hdr[0][31:16]), 64'hFFFF);
    chk("c4_udp_len1", 64'(done_hdr[1][31:16]), 64'hFFFF);

    // Case 6: reset in the middle of a header, then a clean header
    set_case1(16'h0000);
    f0 = frames[0];
    pulse_start();
    k = 0;
    while (cnt[0] < 10 && k < 100) begin tick(); k++; end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("c6_no_partial", 64'(frames[0] - f0), 64'd0);
    pulse_start();
    wait_idle(200);
    chk("c6_hdr0", done_hdr[0], 64'h12345678000C13D6);
    chk("c6_beats0", 64'(done_cnt[0]), 64'd32);

    // Randomized frames with random backpressure and stray starts
    rdy_mode = 2;
    for (int it = 0; it < 25; it++) begin
      src_ip = $urandom; dst_ip = $urandom;
      src_port = 16'($urandom); dst_port = 16'($urandom);
      payload_cksum = 16'($urandom);
      payload_len = ($urandom_range(0, 5) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                                : 16'($urandom_range(0, 16'hFFF7));
      pulse_start();
      for (int c = 0; c < 150 && (m_busy[0] || m_busy[1]); c++) begin
        start = ($urandom_range(0, 19) == 0);
        if (start) begin
          src_port = 16'($urandom);
          payload_len = 16'($urandom_range(0, 2000));
        end
        tick();
      end
      start = 1'b0;
      wait_idle(400);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
